// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin shared bit-serial pattern detector
module seq_detect_sched #(
  parameter int                 NUM_REQ   = 4,
  parameter int                 WORD_W    = 8,
  parameter int                 PAT_W     = 4,
  parameter logic [PAT_W-1:0]   PAT_RESET = 4'b0011,
  localparam int                ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int                CNT_W     = $clog2(WORD_W + 1)
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      bit_en,
  input  logic                      cfg_we,
  input  logic [PAT_W-1:0]          cfg_pattern,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ID_W-1:0]           res_id,
  output logic [CNT_W-1:0]          res_count,
  output logic                      res_hit,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_n;
  logic [PAT_W-1:0]   pattern;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    id_q;
  logic [WORD_W-1:0]  sreg;
  logic [PAT_W-1:0]   hist;
  logic [CNT_W-1:0]   bits_seen;
  logic [CNT_W-1:0]   count;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic [PAT_W-1:0]   hist_n;
  logic [CNT_W-1:0]   seen_n;
  logic               match;
  logic               last_bit;

  // Search upward from the requester after last_grant, wrapping around.
  always_comb begin : arb
    int idx;
    idx     = 0;
    gnt_oh  = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any     = 1'b1;
        gnt_id      = ID_W'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

  assign hist_n   = {hist[PAT_W-2:0], sreg[WORD_W-1]};
  assign seen_n   = bits_seen + 1'b1;
  assign match    = (seen_n >= CNT_W'(PAT_W)) && (hist_n == pattern);
  assign last_bit = (seen_n == CNT_W'(WORD_W));

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    res_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        // No grant during reset: the reset edge would drop the capture.
        if (!rst) req_ready = gnt_oh;
        if (gnt_any) state_n = SHIFT;
      end
      SHIFT: begin
        if (bit_en && last_bit) state_n = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pattern    <= PAT_RESET;
      last_grant <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      sreg       <= '0;
      hist       <= '0;
      bits_seen  <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) pattern <= cfg_pattern;
          if (gnt_any) begin
            sreg       <= req_data[gnt_id*WORD_W +: WORD_W];
            id_q       <= gnt_id;
            last_grant <= gnt_id;
            hist       <= '0;
            bits_seen  <= '0;
            count      <= '0;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            sreg      <= {sreg[WORD_W-2:0], 1'b0};
            hist      <= hist_n;
            bits_seen <= seen_n;
            if (match) count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_id    = id_q;
  assign res_count = count;
  assign res_hit   = |count;

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler that shares a single bit-serial pattern detector between several requesters. Each requester offers one parallel word. The block grants one requester, serialises its word MSB-first into an overlapping Mealy-style pattern matcher, and advances one bit per `bit_en` strobe from the clock divider. It returns the match count tagged with the requester ID, and the match pattern can be reprogrammed at runtime.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WORD_W`, 8: bits per request word.
- `PAT_W`, 4: pattern length, 2..WORD_W.
- `PAT_RESET`, 4'b0011: pattern value loaded on reset.
- `clk_in` input 1: the only clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `bit_en` input 1: shift strobe; one bit is processed per high cycle, only in SHIFT.
- `cfg_we` input 1: pattern write strobe, honoured only in IDLE.
- `cfg_pattern` input PAT_W: new pattern; the LSB is the most recently received bit.
- `req_valid` input NUM_REQ: per-requester word valid.
- `req_data` input NUM_REQ*WORD_W: requester i's word is at slice [i*WORD_W +: WORD_W].
- `req_ready` output NUM_REQ: one-hot grant, combinational, asserted in IDLE only.
- `res_valid` output 1: result available.
- `res_ready` input 1: result consumer ready.
- `res_id` output clog2(NUM_REQ): ID of the granted requester.
- `res_count` output clog2(WORD_W+1): number of matches in the word.
- `res_hit` output 1: high when res_count != 0.
- `busy` output 1: high when the state is not IDLE.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
- **IDLE**
  - With any req_valid set, select the first set bit searching upward from last_grant+1, with wrap-around.
  - Drive req_ready for that bit in the same cycle.
  - At the clock edge: capture the word into the shift register, record res_id and last_grant, clear history, bits_seen and count, then go to SHIFT.
  - If cfg_we is high at the same edge, the pattern updates and applies to this word.
- **SHIFT**, on each bit_en cycle:
  - bit = shift register MSB; shift left.
  - hist_n = {hist[PAT_W-2:0], bit}; bits_seen increments.
  - If bits_seen+1 >= PAT_W and hist_n == pattern, count increments.
  - On the WORD_W-th processed bit, go to DONE.
  - bit_en low: hold all state.
- **Matching rules:** matches may overlap. The history restarts for every word, so windows never span two words.
- **DONE**
  - res_valid is high; res_id, res_count and res_hit are held stable.
  - res_valid && res_ready at an edge: go to IDLE.
- cfg_we in SHIFT or DONE is ignored (not queued).
- bit_en is ignored in IDLE and DONE.
- A requester must hold req_valid and its data until req_ready is seen. Deasserting req_valid before the grant withdraws the request.
- Count width is clog2(WORD_W+1); it cannot overflow because count <= WORD_W-PAT_W+1.

## Timing
- Reset values:
  - state = IDLE, pattern = PAT_RESET, last_grant = NUM_REQ-1 (requester 0 has first priority).
  - res_valid = 0, res_id = 0, res_count = 0, res_hit = 0, busy = 0.
  - req_ready = 0, shift register, history and bits_seen all cleared.
- Reset in SHIFT or DONE: the word and its result are discarded (the requester's handshake has already completed). Outputs take their reset values in the cycle after the reset edge.
- Latency with bit_en tied high, grant at edge 0:
  - bits are processed at edges 1..WORD_W;
  - res_valid is high from the cycle after edge WORD_W (cycle WORD_W+1).
- In general, res_valid follows the edge of the WORD_W-th qualified bit_en by one cycle.
- Minimum spacing between grants is WORD_W+2 cycles: one cycle in DONE, one in IDLE, WORD_W in SHIFT.
- res_ready held low stalls DONE indefinitely; outputs remain constant.

## Test plan
- **Reset defaults:** assert rst for 2 cycles, all inputs 0.
  - Required: busy=0, res_valid=0, req_ready=0.
  - Then req0 with 8'b0011_0000 gives count 1, confirming pattern 0011.
- **Single word, full rate:** req_valid=4'b0001, data0=8'b0011_0011, bit_en=1, res_ready=1.
  - Required: req_ready=4'b0001 in cycle 0, then res_valid=1 in cycle 9 only, with res_id=0, res_count=2, res_hit=1.
- **Overlap and reconfiguration:** cfg_we with 4'b1010 in IDLE together with req2 data 8'b1010_1010.
  - Required: res_id=2, res_count=3.
  - A cfg_we pulse during SHIFT leaves the pattern at 1010.
- **Round-robin fairness:** all four req_valid held high.
  - Required: grant order 0,1,2,3,0,1; each requester gets exactly one req_ready per round.
- **Throttled and backpressure:** bit_en high every 4th cycle, data1=8'h00, res_ready low for 5 cycles after res_valid.
  - Required: res_valid appears one cycle after the 8th strobe with res_count=0, res_hit=0, held stable for all stall cycles.
  - busy stays high until the cycle after res_ready is sampled.
- **Reset mid-shift:** assert rst after 3 bits of a word when the pattern has been set to 1010.
  - Required: busy=0 and res_valid=0 in the next cycle, no result is ever produced, pattern reverts to 0011.
  - The next grant goes to requester 0.
